obstacle_scheduler: RTL
=======================

# obstacle_scheduler

Parametrised obstacle slot manager for the runner level: allocates up to NSLOT concurrent obstacles on a programmable spawn interval, assigns each a random type and lane height, scrolls them left at a runtime-selectable speed, and retires them at the left margin. It sits between the game FSM and the per-obstacle sprite/ROM instances, replacing the fixed three-slot, derived-clock logic with single-clock, strobe-driven, registered outputs.

## Interface
- NSLOT, 3: number of obstacle slots (1..8)
- CORDW, 10: coordinate width
- CDW, 16: cooldown counter width
- RANDW, 13: random input width (≥2)
- X_SPAWN, 780: x loaded into a free or retired slot
- X_DESPAWN, 80: left retire threshold
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-low reset
- spawn_tick  in  1  one-cycle strobe advancing the spawn cooldown
- move_tick  in  1  one-cycle strobe advancing obstacle positions
- mode  in  2  0 STOP (clear), 1 RUN, 2 FREEZE, 3 treated as FREEZE
- rand  in  RANDW  LFSR value; only bits [1:0] used
- spawn_gap  in  CDW  spawn_ticks between spawns
- speed  in  3  pixels per move_tick; 0 treated as 1
- busy  out  NSLOT  slot occupied
- obs_x  out  NSLOT*CORDW  slot i at [i*CORDW +: CORDW]
- obs_y  out  NSLOT*CORDW  lane y per slot
- obs_type  out  NSLOT*2  type per slot
- spawn_pulse  out  1  one-cycle, slot allocated
- spawn_idx  out  3  slot index of last allocation
- despawn_pulse  out  1  one-cycle, ≥1 slot retired
- overflow_pulse  out  1  one-cycle, spawn due but all slots busy
- active_count  out  4  popcount of busy

## Operation
- Type from rand[1:0]: 0 HIGH_A y=160, 1 HIGH_B y=200, 2 LOW_CACTUS y=245, 3 LOW_ROCK y=245.
- RUN, spawn: on spawn_tick, if cooldown < spawn_gap then cooldown+1; else if any slot free (registered busy), allocate the lowest-index free slot (busy=1, x=X_SPAWN, y/type from rand), cooldown=0, spawn_pulse=1; else cooldown holds, overflow_pulse=1.
- spawn_gap=0: spawn attempted on every spawn_tick.
- RUN, move: on move_tick, each busy slot with x > X_DESPAWN+step gets x -= step (step = speed, or 1 if 0); otherwise busy=0, x=X_SPAWN, type/y hold, despawn_pulse=1. Arithmetic never underflows below X_DESPAWN.
- FREEZE: all state and outputs hold; strobes ignored; pulses 0.
- STOP: next edge clears all busy, x=X_SPAWN, y=0, type=0, cooldown=0.
- Slot freed in cycle N is not allocatable until cycle N+1.
- spawn_tick and move_tick in the same cycle: the newly allocated slot is not moved that cycle; other slots move normally.
- A mode change mid-operation takes effect at the next edge; no partial updates.

## Timing
- All outputs registered; response visible one cycle after the strobe edge.
- Reset (RESET=0 at edge): busy=0, obs_x all X_SPAWN, obs_y 0, obs_type 0, cooldown 0, spawn_idx 0, all pulses 0, active_count 0. Reset dominates mode and strobes.
- active_count reflects busy of the same cycle (computed from next-state).
- Pulses are exactly one cycle per triggering strobe; never asserted in STOP/FREEZE.

## Structure
- Shared package level_pkg: mode encodings, obstacle type enum, lane y constants (160/200/245), type-to-lane function.
- Sub-module obstacle_slot: one slot's busy/x/y/type registers, load and move/retire logic; instantiated NSLOT times via generate.
- Top holds cooldown, priority free-slot encoder, pulse and popcount logic.

## Test plan
- Reset then RUN, spawn_gap=2, rand=2: third spawn_tick -> slot 0 busy, x=780, y=245, type 2, spawn_pulse one cycle, spawn_idx=0.
- speed=0 then speed=5 with 10 move_ticks each on slot 0 -> x 770, then 720.
- Slot at x=84, speed=4, move_tick -> busy=0, x=780, despawn_pulse; at x=85 -> x=81, stays busy.
- NSLOT=3, gap=0, all slots busy, spawn_tick -> overflow_pulse, no state change; retire slot 1 and spawn in the same cycle -> no allocation; next spawn_tick -> spawn_idx=1.
- spawn_tick+move_tick same cycle -> new slot at 780, existing slot decremented by speed.
- FREEZE for 50 ticks -> all outputs unchanged; STOP -> busy=0, active_count=0 next cycle; RESET mid-RUN -> reset values.

Source files
------------

// File: rtl/obstacle_scheduler_pkg.sv
// Shared definitions for the runner-level obstacle logic: operating modes,
// obstacle types and the lane height each type runs in.
package obstacle_scheduler_pkg;

    typedef enum logic [1:0] {
        MODE_STOP       = 2'd0,
        MODE_RUN        = 2'd1,
        MODE_FREEZE     = 2'd2,
        MODE_FREEZE_ALT = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        OBS_HIGH_A     = 2'd0,
        OBS_HIGH_B     = 2'd1,
        OBS_LOW_CACTUS = 2'd2,
        OBS_LOW_ROCK   = 2'd3
    } obs_type_e;

    localparam logic [7:0] LANE_Y_HIGH_A = 8'd160;
    localparam logic [7:0] LANE_Y_HIGH_B = 8'd200;
    localparam logic [7:0] LANE_Y_LOW    = 8'd245;

    function automatic logic [7:0] lane_y(input obs_type_e t);
        case (t)
            OBS_HIGH_A: lane_y = LANE_Y_HIGH_A;
            OBS_HIGH_B: lane_y = LANE_Y_HIGH_B;
            default:    lane_y = LANE_Y_LOW;
        endcase
    endfunction

endpackage

// File: rtl/obstacle_scheduler_slot.sv
// One obstacle slot: occupancy, position, lane and type registers with
// load (spawn), scroll and left-margin retire behaviour.
module obstacle_scheduler_slot
    import obstacle_scheduler_pkg::*;
#(
    parameter int CORDW     = 10,
    parameter int X_SPAWN   = 780,
    parameter int X_DESPAWN = 80
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [1:0]       type_i,
    input  logic             move_i,
    input  logic [2:0]       step_i,
    output logic             busy_o,
    output logic [CORDW-1:0] x_o,
    output logic [CORDW-1:0] y_o,
    output logic [1:0]       type_o,
    output logic             busy_next_o,
    output logic             retire_o
);

    localparam logic [CORDW-1:0] XSPAWN_C = CORDW'(X_SPAWN);
    localparam logic [CORDW:0]   XDESP_C  = (CORDW+1)'(X_DESPAWN);

    logic             busy_q, busy_d;
    logic [CORDW-1:0] x_q, x_d;
    logic [CORDW-1:0] y_q, y_d;
    logic [1:0]       type_q, type_d;
    logic [CORDW:0]   thresh_s;
    logic             retire_s;

    // Next-state: clear beats load; load only targets a free slot, so it never
    // coincides with a move of the same slot.
    always_comb begin
        busy_d   = busy_q;
        x_d      = x_q;
        y_d      = y_q;
        type_d   = type_q;
        retire_s = 1'b0;
        thresh_s = XDESP_C + (CORDW+1)'(step_i);
        if (clear_i) begin
            busy_d = 1'b0;
            x_d    = XSPAWN_C;
            y_d    = {CORDW{1'b0}};
            type_d = 2'd0;
        end else if (load_i) begin
            busy_d = 1'b1;
            x_d    = XSPAWN_C;
            type_d = type_i;
            y_d    = CORDW'(lane_y(obs_type_e'(type_i)));
        end else if (move_i && busy_q) begin
            if ({1'b0, x_q} > thresh_s) begin
                x_d = x_q - CORDW'(step_i);
            end else begin
                busy_d   = 1'b0;
                x_d      = XSPAWN_C;
                retire_s = 1'b1;
            end
        end else begin
            busy_d = busy_q;
        end
    end

    // Slot state registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            busy_q <= 1'b0;
            x_q    <= XSPAWN_C;
            y_q    <= {CORDW{1'b0}};
            type_q <= 2'd0;
        end else begin
            busy_q <= busy_d;
            x_q    <= x_d;
            y_q    <= y_d;
            type_q <= type_d;
        end
    end

    assign busy_o      = busy_q;
    assign x_o         = x_q;
    assign y_o         = y_q;
    assign type_o      = type_q;
    assign busy_next_o = busy_d;
    assign retire_o    = retire_s;

endmodule

// File: rtl/obstacle_scheduler.sv
// Obstacle slot manager: spawn cooldown, lowest-free-slot allocation,
// per-slot scrolling, and registered event pulses / occupancy count.
module obstacle_scheduler
    import obstacle_scheduler_pkg::*;
#(
    parameter int NSLOT     = 3,
    parameter int CORDW     = 10,
    parameter int CDW       = 16,
    parameter int RANDW     = 13,
    parameter int X_SPAWN   = 780,
    parameter int X_DESPAWN = 80
) (
    input  logic                   clk_i,
    input  logic                   reset_ni,
    input  logic                   spawn_tick_i,
    input  logic                   move_tick_i,
    input  logic [1:0]             mode_i,
    input  logic [RANDW-1:0]       rand_i,
    input  logic [CDW-1:0]         spawn_gap_i,
    input  logic [2:0]             speed_i,
    output logic [NSLOT-1:0]       busy_o,
    output logic [NSLOT*CORDW-1:0] obs_x_o,
    output logic [NSLOT*CORDW-1:0] obs_y_o,
    output logic [NSLOT*2-1:0]     obs_type_o,
    output logic                   spawn_pulse_o,
    output logic [2:0]             spawn_idx_o,
    output logic                   despawn_pulse_o,
    output logic                   overflow_pulse_o,
    output logic [3:0]             active_count_o
);

    logic [CDW-1:0]   cooldown_q, cooldown_d;
    logic [2:0]       spawn_idx_q, spawn_idx_d;
    logic             spawn_pulse_q, spawn_pulse_d;
    logic             despawn_pulse_q, despawn_pulse_d;
    logic             overflow_pulse_q, overflow_pulse_d;
    logic [3:0]       active_count_q, active_count_d;

    logic [NSLOT-1:0] slot_busy_s, slot_busy_next_s, slot_retire_s;
    logic             free_found_s;
    logic [2:0]       free_idx_s;
    logic             alloc_s, clear_s, run_s, move_s;
    logic [2:0]       step_s;
    logic             unused_rand_s;

    assign unused_rand_s = ^rand_i;
    assign step_s        = (speed_i == 3'd0) ? 3'd1 : speed_i;
    assign move_s        = run_s & move_tick_i;

    for (genvar g = 0; g < NSLOT; g++) begin : g_slot
        obstacle_scheduler_slot #(
            .CORDW     (CORDW),
            .X_SPAWN   (X_SPAWN),
            .X_DESPAWN (X_DESPAWN)
        ) u_slot (
            .clk_i       (clk_i),
            .rst_ni      (reset_ni),
            .clear_i     (clear_s),
            .load_i      (alloc_s && (free_idx_s == 3'(g))),
            .type_i      (rand_i[1:0]),
            .move_i      (move_s),
            .step_i      (step_s),
            .busy_o      (slot_busy_s[g]),
            .x_o         (obs_x_o[g*CORDW +: CORDW]),
            .y_o         (obs_y_o[g*CORDW +: CORDW]),
            .type_o      (obs_type_o[g*2 +: 2]),
            .busy_next_o (slot_busy_next_s[g]),
            .retire_o    (slot_retire_s[g])
        );
    end

    // Lowest-index free slot, judged on registered occupancy so a slot
    // retiring this cycle only becomes allocatable next cycle.
    always_comb begin
        free_found_s = 1'b0;
        free_idx_s   = 3'd0;
        for (int i = NSLOT - 1; i >= 0; i--) begin
            if (!slot_busy_s[i]) begin
                free_found_s = 1'b1;
                free_idx_s   = 3'(i);
            end else begin
                free_found_s = free_found_s;
            end
        end
    end

    // Mode decode, spawn cooldown and allocation decision.
    always_comb begin
        cooldown_d       = cooldown_q;
        spawn_idx_d      = spawn_idx_q;
        spawn_pulse_d    = 1'b0;
        overflow_pulse_d = 1'b0;
        alloc_s          = 1'b0;
        clear_s          = 1'b0;
        run_s            = 1'b0;
        case (mode_e'(mode_i))
            MODE_STOP: begin
                clear_s    = 1'b1;
                cooldown_d = {CDW{1'b0}};
            end
            MODE_RUN: begin
                run_s = 1'b1;
                if (spawn_tick_i) begin
                    if (cooldown_q < spawn_gap_i) begin
                        cooldown_d = cooldown_q + {{(CDW-1){1'b0}}, 1'b1};
                    end else if (free_found_s) begin
                        alloc_s       = 1'b1;
                        cooldown_d    = {CDW{1'b0}};
                        spawn_pulse_d = 1'b1;
                        spawn_idx_d   = free_idx_s;
                    end else begin
                        overflow_pulse_d = 1'b1;
                    end
                end else begin
                    cooldown_d = cooldown_q;
                end
            end
            default: begin
                run_s = 1'b0;
            end
        endcase
    end

    // Despawn pulse and occupancy count follow the slots' next state so they
    // line up with the registered slot outputs.
    always_comb begin
        despawn_pulse_d = |slot_retire_s;
        active_count_d  = 4'd0;
        for (int i = 0; i < NSLOT; i++) begin
            active_count_d = active_count_d + 4'(slot_busy_next_s[i]);
        end
    end

    // Scheduler registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            cooldown_q       <= {CDW{1'b0}};
            spawn_idx_q      <= 3'd0;
            spawn_pulse_q    <= 1'b0;
            despawn_pulse_q  <= 1'b0;
            overflow_pulse_q <= 1'b0;
            active_count_q   <= 4'd0;
        end else begin
            cooldown_q       <= cooldown_d;
            spawn_idx_q      <= spawn_idx_d;
            spawn_pulse_q    <= spawn_pulse_d;
            despawn_pulse_q  <= despawn_pulse_d;
            overflow_pulse_q <= overflow_pulse_d;
            active_count_q   <= active_count_d;
        end
    end

    assign busy_o           = slot_busy_s;
    assign spawn_pulse_o    = spawn_pulse_q;
    assign spawn_idx_o      = spawn_idx_q;
    assign despawn_pulse_o  = despawn_pulse_q;
    assign overflow_pulse_o = overflow_pulse_q;
    assign active_count_o   = active_count_q;

endmodule
